// File: rtl/filter_select.sv
// ============================================================================
// Module   : filter_select
// Purpose  : Debounces the filter switches and applies a legal selection only
//            on a video frame boundary.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_select #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] sw_raw,
  input  logic       frame_start,
  output logic [4:0] filter_sel,
  output logic       pending,
  output logic       changed,
  output logic       err
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  logic [4:0]       r_sync1;
  logic [4:0]       r_sw_s;
  logic [4:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_stab;
  logic [4:0]       r_req;
  logic             r_err;
  state_t           r_state;
  logic [4:0]       r_sel;
  logic             r_changed;

  state_t           w_state_next;
  logic [4:0]       w_sel_next;
  logic             w_changed_next;

  function automatic logic is_legal(input logic [4:0] v);
    return (v & (v - 5'd1)) == 5'd0;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sw_s  <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sw_s  <= r_sync1;
    end
  end

  // req and err follow stab in the same edge so the FSM sees a new request one
  // cycle after it is debounced.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_stab <= '0;
      r_req  <= '0;
      r_err  <= 1'b0;
    end else if (r_sw_s != r_cand) begin
      r_cand <= r_sw_s;
      r_cnt  <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_stab <= r_cand;
      if (is_legal(r_cand)) begin
        r_req <= r_cand;
        r_err <= 1'b0;
      end else begin
        r_err <= 1'b1;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sel     <= w_sel_next;
      r_changed <= w_changed_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_sel_next     = r_sel;
    w_changed_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_req != r_sel) w_state_next = PEND;
      end
      PEND: begin
        if (frame_start) begin
          w_sel_next     = r_req;
          w_changed_next = (r_req != r_sel);
          w_state_next   = IDLE;
        end else if (r_req == r_sel) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign filter_sel = r_sel;
  assign pending    = (r_state == PEND);
  assign changed    = r_changed;
  assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_filter_select.sv
// ============================================================================
// Module   : tb_filter_select
// Purpose  : Self-checking bench for filter_select with a short debounce.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filter_select;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] sw_raw;
  logic       frame_start;
  logic [4:0] filter_sel;
  logic       pending;
  logic       changed;
  logic       err;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] prev_sel = '0;

  filter_select #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .frame_start(frame_start),
    .filter_sel (filter_sel),
    .pending    (pending),
    .changed    (changed),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  // Scoreboard: every changed pulse must match the next expected selection,
  // and filter_sel may only move together with a changed pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_sel = filter_sel;
    end else begin
      if (changed) begin
        if (exp_q.size() == 0) check("sb_unexpected", {31'd0, changed}, 32'd0);
        else                   check("sb_sel", {27'd0, filter_sel}, {27'd0, exp_q.pop_front()});
      end
      if (filter_sel != prev_sel) begin
        check("sel_onehot0", {31'd0, $onehot0(filter_sel)}, 32'd1);
        check("sel_chg_pulse", {31'd0, changed}, 32'd1);
      end
      prev_sel = filter_sel;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n     = 1'b0;
    sw_raw      = 5'b00000;
    frame_start = 1'b0;
    tick(3);
    check("rst_sel",     {27'd0, filter_sel}, 32'd0);
    check("rst_pending", {31'd0, pending},    32'd0);
    check("rst_changed", {31'd0, changed},    32'd0);
    check("rst_err",     {31'd0, err},        32'd0);
    reset_n = 1'b1;
    tick(10);

    // Short glitch must never reach the selection logic
    sw_raw = 5'b00010;
    tick(3);
    sw_raw = 5'b00000;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("glitch_pending", {31'd0, pending}, 32'd0);
    end
    check("glitch_sel", {27'd0, filter_sel}, 32'd0);

    // Basic apply: stab at edge 7, pending at edge 8, applied on frame_start
    sw_raw = 5'b00001;
    tick(7);
    check("t1_pend_early", {31'd0, pending}, 32'd0);
    tick(1);
    check("t1_pend",       {31'd0, pending}, 32'd1);
    check("t1_sel_hold",   {27'd0, filter_sel}, 32'd0);
    exp_q.push_back(5'b00001);
    frame();
    check("t1_sel",        {27'd0, filter_sel}, 32'h01);
    check("t1_changed",    {31'd0, changed}, 32'd1);
    tick(1);
    check("t1_changed_off", {31'd0, changed}, 32'd0);
    check("t1_pend_off",   {31'd0, pending}, 32'd0);
    frame();
    check("t1_idle_frame", {27'd0, filter_sel}, 32'h01);

    // Illegal multi-bit selection raises err and is ignored
    sw_raw = 5'b00110;
    tick(8);
    check("t3_err",     {31'd0, err},     32'd1);
    check("t3_pending", {31'd0, pending}, 32'd0);
    frame();
    check("t3_sel",     {27'd0, filter_sel}, 32'h01);
    sw_raw = 5'b00100;
    tick(8);
    check("t3_err_off", {31'd0, err},     32'd0);
    check("t3_pend",    {31'd0, pending}, 32'd1);
    exp_q.push_back(5'b00100);
    frame();
    check("t3_sel_new", {27'd0, filter_sel}, 32'h04);

    // Request reverts before a frame boundary
    sw_raw = 5'b01000;
    tick(8);
    check("t4_pend",     {31'd0, pending}, 32'd1);
    sw_raw = 5'b00100;
    tick(8);
    check("t4_pend_off", {31'd0, pending}, 32'd0);
    frame();
    check("t4_sel",      {27'd0, filter_sel}, 32'h04);

    // Request changes while pending: latest value wins
    sw_raw = 5'b10000;
    tick(8);
    check("t5_pend_a", {31'd0, pending}, 32'd1);
    sw_raw = 5'b00010;
    tick(8);
    check("t5_pend_b", {31'd0, pending}, 32'd1);
    exp_q.push_back(5'b00010);
    frame();
    check("t5_sel",    {27'd0, filter_sel}, 32'h02);

    // frame_start coinciding with IDLE->PEND is ignored; back-to-back frames apply once
    sw_raw = 5'b00001;
    tick(7);
    frame();
    check("t6_pend_same", {31'd0, pending}, 32'd1);
    check("t6_sel_same",  {27'd0, filter_sel}, 32'h02);
    exp_q.push_back(5'b00001);
    frame_start = 1'b1;
    tick(2);
    frame_start = 1'b0;
    check("t6_b2b_sel",   {27'd0, filter_sel}, 32'h01);
    check("t6_b2b_pend",  {31'd0, pending}, 32'd0);

    // Reset while pending discards the request; held switch re-debounces
    sw_raw = 5'b01000;
    tick(8);
    check("t7_pend", {31'd0, pending}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t7_rst_sel",     {27'd0, filter_sel}, 32'd0);
    check("t7_rst_pending", {31'd0, pending},    32'd0);
    check("t7_rst_changed", {31'd0, changed},    32'd0);
    check("t7_rst_err",     {31'd0, err},        32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(6);
    check("t7_pend_early", {31'd0, pending}, 32'd0);
    tick(2);
    check("t7_pend_again", {31'd0, pending}, 32'd1);
    check("t7_sel_zero",   {27'd0, filter_sel}, 32'd0);
    exp_q.push_back(5'b01000);
    frame();
    check("t7_sel",        {27'd0, filter_sel}, 32'h08);

    tick(4);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
